// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt aggregator with claim/complete
// handshake feeding the single external_int line of the cpu core.
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [2:0]       bus_addr,
  input  logic             bus_ren,
  input  logic             bus_wen,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             external_int
);

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_EN    = 3'd1;
  localparam logic [2:0] A_EDGE  = 3'd2;
  localparam logic [2:0] A_CLAIM = 3'd3;
  localparam logic [2:0] A_INSV  = 3'd4;

  logic [N_SRC-1:0] s1, s2, s3;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] edge_mode;
  logic [N_SRC-1:0] inservice;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] cand_oh;
  logic [N_SRC-1:0] cmp_oh;
  logic [N_SRC-1:0] claim_oh;
  logic [N_SRC-1:0] done_oh;
  logic [N_SRC-1:0] w1c;
  logic [31:0]      cand_id;
  logic [31:0]      rd_mux;
  logic             rd_en;
  logic             claim;

  function automatic logic [31:0] zx(input logic [N_SRC-1:0] v);
    zx = '0;
    zx[N_SRC-1:0] = v;
  endfunction

  assign rise = s2 & ~s3;
  // level sources mirror the synchronizer directly
  assign pend = (edge_mode & pend_q) | (~edge_mode & s2);
  assign act  = pend & enable & ~inservice;

  // a simultaneous write wins and suppresses the read entirely
  assign rd_en = bus_ren & ~bus_wen;
  assign claim = rd_en && (bus_addr == A_CLAIM);

  always_comb begin
    cand_oh = '0;
    cand_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) begin
        cand_oh    = '0;
        cand_oh[i] = 1'b1;
        cand_id    = 32'(i + 1);
      end
    end
  end

  always_comb begin
    cmp_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cmp_oh[i] = (bus_wdata == 32'(i + 1));
    end
  end

  assign claim_oh = claim ? cand_oh : '0;
  assign done_oh  = (bus_wen && bus_addr == A_CLAIM) ? cmp_oh : '0;
  assign w1c      = (bus_wen && bus_addr == A_PEND)
                  ? (bus_wdata[N_SRC-1:0] & edge_mode) : '0;

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      A_PEND:  rd_mux = zx(pend);
      A_EN:    rd_mux = zx(enable);
      A_EDGE:  rd_mux = zx(edge_mode);
      A_CLAIM: rd_mux = cand_id;
      A_INSV:  rd_mux = zx(inservice);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      pend_q       <= '0;
      enable       <= '0;
      edge_mode    <= '0;
      inservice    <= '0;
      bus_rdata    <= '0;
      external_int <= 1'b0;
    end else begin
      s1 <= src_irq;
      s2 <= s1;
      s3 <= s2;
      // rise is OR-ed last so a same-cycle set beats claim/W1C
      pend_q <= ((pend_q & ~(w1c | claim_oh)) | rise) & edge_mode;
      inservice <= (inservice | claim_oh) & ~done_oh;
      if (bus_wen && bus_addr == A_EN)
        enable <= bus_wdata[N_SRC-1:0];
      if (bus_wen && bus_addr == A_EDGE)
        edge_mode <= bus_wdata[N_SRC-1:0];
      if (rd_en)
        bus_rdata <= rd_mux;
      external_int <= |act;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed checks of irq_ctrl with hand-computed
// expectations; inputs change and outputs are sampled on negedge.
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  src_irq;
  logic [2:0]  bus_addr;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        external_int;

  int checks;
  int errors;

  irq_ctrl #(.N_SRC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_irq      (src_irq),
    .bus_addr     (bus_addr),
    .bus_ren      (bus_ren),
    .bus_wen      (bus_wen),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .external_int (external_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wen   = 1'b1;
    @(negedge clk);
    bus_wen   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_ren  = 1'b1;
    @(negedge clk);
    bus_ren  = 1'b0;
    d = bus_rdata;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] v;
  logic [31:0] held;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    src_irq   = '0;
    bus_addr  = '0;
    bus_ren   = 1'b0;
    bus_wen   = 1'b0;
    bus_wdata = '0;
    idle(3);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_ext", {31'b0, external_int}, 32'h0);
    rst = 1'b0;
    rd(3'd1, v); chk("rst_en", v, 32'h0);
    rd(3'd2, v); chk("rst_edge", v, 32'h0);

    // edge source 0, single-cycle pulse
    wr(3'd2, 32'h01);
    wr(3'd1, 32'h01);
    src_irq = 8'h01;
    @(negedge clk);
    src_irq = 8'h00;
    idle(2);
    rd(3'd0, v); chk("e_pend", v, 32'h01);
    chk("e_ext1", {31'b0, external_int}, 32'h1);
    rd(3'd3, v); chk("e_claim", v, 32'h1);
    rd(3'd0, v); chk("e_pend0", v, 32'h0);
    chk("e_ext0", {31'b0, external_int}, 32'h0);
    rd(3'd4, v); chk("e_insv", v, 32'h01);
    wr(3'd3, 32'h1);
    rd(3'd4, v); chk("e_done", v, 32'h0);

    // level sources 2 and 5, priority and re-assert
    do_rst();
    wr(3'd1, 32'hFF);
    src_irq = 8'h24;
    idle(3);
    rd(3'd3, v); chk("l_c3", v, 32'h3);
    rd(3'd3, v); chk("l_c6", v, 32'h6);
    rd(3'd3, v); chk("l_c0", v, 32'h0);
    chk("l_ext0", {31'b0, external_int}, 32'h0);
    wr(3'd3, 32'h3);
    @(negedge clk);
    chk("l_ext1", {31'b0, external_int}, 32'h1);
    rd(3'd3, v); chk("l_c3b", v, 32'h3);
    src_irq = 8'h00;

    // rising edge lands on the same posedge as claim of ID 2
    do_rst();
    wr(3'd2, 32'h02);
    wr(3'd1, 32'h02);
    src_irq = 8'h02;
    @(negedge clk);
    src_irq = 8'h00;
    idle(4);
    src_irq = 8'h02;
    idle(2);
    rd(3'd3, v); chk("r_claim", v, 32'h2);
    rd(3'd0, v); chk("r_pend", v, 32'h02);
    rd(3'd4, v); chk("r_insv", v, 32'h02);
    src_irq = 8'h00;

    // W1C on edge and on level source
    do_rst();
    wr(3'd2, 32'h01);
    wr(3'd1, 32'h01);
    src_irq = 8'h01;
    @(negedge clk);
    src_irq = 8'h00;
    idle(4);
    wr(3'd0, 32'h01);
    rd(3'd0, v); chk("w_pend0", v, 32'h0);
    chk("w_ext0", {31'b0, external_int}, 32'h0);
    wr(3'd2, 32'h00);
    src_irq = 8'h01;
    idle(3);
    wr(3'd0, 32'h01);
    rd(3'd0, v); chk("w_lvl", v, 32'h01);
    src_irq = 8'h00;

    // disabled pending, late enable, bogus completes
    do_rst();
    src_irq = 8'h08;
    idle(3);
    rd(3'd0, v); chk("d_pend", v, 32'h08);
    chk("d_ext0", {31'b0, external_int}, 32'h0);
    wr(3'd1, 32'h08);
    chk("d_ext_w", {31'b0, external_int}, 32'h0);
    @(negedge clk);
    chk("d_ext1", {31'b0, external_int}, 32'h1);
    rd(3'd3, v); chk("d_claim", v, 32'h4);
    wr(3'd3, 32'h0);
    wr(3'd3, 32'h9);
    rd(3'd4, v); chk("d_insv", v, 32'h08);
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, v); chk("d_enmask", v, 32'hFF);
    rd(3'd5, v); chk("d_addr5", v, 32'h0);

    // reset mid-claim, then simultaneous read/write on CLAIM
    rd(3'd3, v);
    rd(3'd4, v); chk("x_pre", v, 32'h08);
    do_rst();
    chk("x_rdata", bus_rdata, 32'h0);
    chk("x_ext", {31'b0, external_int}, 32'h0);
    rd(3'd4, v); chk("x_insv", v, 32'h0);
    rd(3'd1, v); chk("x_en", v, 32'h0);
    wr(3'd1, 32'h08);
    idle(3);
    rd(3'd1, held);
    bus_addr  = 3'd3;
    bus_wdata = 32'h0;
    bus_ren   = 1'b1;
    bus_wen   = 1'b1;
    @(negedge clk);
    bus_ren   = 1'b0;
    bus_wen   = 1'b0;
    chk("x_hold", bus_rdata, held);
    rd(3'd4, v); chk("x_noclm", v, 32'h0);
    rd(3'd3, v); chk("x_claim", v, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
